// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU (WIDTH-cycle radix-2 iteration plus one fix-up cycle)
// and single-cycle MTHI/MTLO. Handshake: start (sampled in idle), busy, done pulse.
// Optional feature macro MDU_DIVZERO_EN: adds a divzero output and makes divide by zero
// skip the iteration phase, returning lo=all ones, hi=srca.
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_EN
  ,
  output logic             divzero
`endif
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  state_e            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [W2-1:0]     acc_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]  b_q;       // multiplicand / divisor magnitude
  logic              is_div_q;
  logic              neg_q_q;   // negate product / quotient in the fix-up cycle
  logic              neg_r_q;   // negate remainder (dividend was negative)
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
`ifdef MDU_DIVZERO_EN
  logic              dz_q;
  logic              divzero_q;
`endif

  // Operand decode and magnitudes at accept time
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             dz_take;

  // Per-iteration datapath
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_cand;
  logic [WIDTH-1:0] div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;

  // Fix-up results
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] hi_fix;
  logic [WIDTH-1:0] lo_fix;

  // Operand sign handling for the accept cycle
  always_comb begin
    signed_op = ~mdop[0];
    a_neg     = signed_op & srca[WIDTH-1];
    b_neg     = signed_op & srcb[WIDTH-1];
    // Negating the most negative value wraps to itself, which is the correct magnitude.
    a_mag     = a_neg ? ('0 - srca) : srca;
    b_mag     = b_neg ? ('0 - srcb) : srcb;
`ifdef MDU_DIVZERO_EN
    dz_take   = (mdop[2:1] == 2'b01) && (srcb == '0);
`else
    dz_take   = 1'b0;
`endif
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  always_comb begin
    mul_addend = acc_q[0] ? b_q : '0;
    mul_sum    = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    div_cand   = acc_q[W2-1:WIDTH-1];
    div_ge     = div_cand >= {1'b0, b_q};
    // When div_ge the difference is below the divisor, so WIDTH bits suffice.
    div_trial  = div_cand[WIDTH-1:0] - b_q;
    div_rem    = div_ge ? div_trial : div_cand[WIDTH-1:0];
    div_next   = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  // Sign correction applied in the fix-up cycle
  always_comb begin
    prod_fix = neg_q_q ? ('0 - acc_q) : acc_q;
    quo_fix  = neg_q_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? ('0 - acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
    if (is_div_q) begin
      hi_fix = rem_fix;
      lo_fix = quo_fix;
    end else begin
      hi_fix = prod_fix[W2-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM with datapath and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MDU_DIVZERO_EN
      dz_q      <= 1'b0;
      divzero_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
`ifdef MDU_DIVZERO_EN
      divzero_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (start) begin
            if (!mdop[2]) begin
              state_q  <= dz_take ? StFix : StCalc;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              is_div_q <= mdop[1];
              b_q      <= b_mag;
              // Divide by zero under the macro bypasses iteration with a preset result.
              acc_q    <= dz_take ? {srca, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
              neg_q_q  <= ~dz_take & (a_neg ^ b_neg);
              neg_r_q  <= ~dz_take & a_neg;
`ifdef MDU_DIVZERO_EN
              dz_q     <= dz_take;
`endif
            end else if (!mdop[1]) begin
              if (mdop[0]) begin
                lo_q <= srca;
              end else begin
                hi_q <= srca;
              end
            end
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!flush) begin
            hi_q      <= hi_fix;
            lo_q      <= lo_fix;
            done_q    <= 1'b1;
`ifdef MDU_DIVZERO_EN
            divzero_q <= dz_q;
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
`ifdef MDU_DIVZERO_EN
  assign divzero = divzero_q;
`endif

endmodule
